// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - registered EX operand forwarding selects, load-use stall and store-data MEM-to-MEM forwarding.
// Optional stall_count output enabled by defining FWD_STALL_COUNT_EN.
module fwd_hazard_unit #(
  parameter int REG_BITS   = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          id_memwrite,
  input  logic [REG_BITS-1:0]           id_rd,
  input  logic [NUM_SRC*REG_BITS-1:0]   id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          ext_hold,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
  output logic                          ex_fwd_mm
`ifdef FWD_STALL_COUNT_EN
  ,
  output logic [15:0]                   stall_count
`endif
);

  // Entry j describes the instruction that is j positions past ID/EX (p0 = in EX).
  logic [FWD_DEPTH-1:0] t_valid;
  logic [FWD_DEPTH-1:0] t_regwrite;
  logic [FWD_DEPTH-1:0] t_memread;
  logic [REG_BITS-1:0]  t_rd [FWD_DEPTH];

  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic                     mm_next;
  logic                     hazard;
  logic [REG_BITS-1:0]      src;
  logic                     hit;
  logic                     hit_load;
  int                       hit_dist;

  always_comb begin
    sel_next = '0;
    mm_next  = 1'b0;
    hazard   = 1'b0;
    src      = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_dist = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src      = id_src[i*REG_BITS +: REG_BITS];
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_dist = 0;
      // Scan oldest to youngest so the youngest producer is the last to overwrite.
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (t_valid[j] && t_regwrite[j] && (t_rd[j] == src)) begin
          hit      = 1'b1;
          hit_load = t_memread[j];
          hit_dist = j + 1;
        end
      end
      if (id_src_used[i] && (src != '0) && hit) begin
        if (hit_load && (hit_dist < LOAD_STAGE)) begin
          if ((i == 1) && id_memwrite && (hit_dist == 1) && (LOAD_STAGE == 2))
            mm_next = 1'b1;
          else
            hazard = 1'b1;
        end else begin
          sel_next[i*SEL_W +: SEL_W] = SEL_W'(hit_dist);
        end
      end
    end
  end

  assign stall = id_valid & hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid    <= '0;
      t_regwrite <= '0;
      t_memread  <= '0;
      for (int j = 0; j < FWD_DEPTH; j++) t_rd[j] <= '0;
      ex_fwd_sel <= '0;
      ex_fwd_mm  <= 1'b0;
    end else if (!ext_hold) begin
      for (int j = FWD_DEPTH - 1; j > 0; j--) begin
        // A flush kills the branch in EX, so it moves on as a bubble.
        if ((j == 1) && flush) t_valid[j] <= 1'b0;
        else                   t_valid[j] <= t_valid[j-1];
        t_regwrite[j] <= t_regwrite[j-1];
        t_memread[j]  <= t_memread[j-1];
        t_rd[j]       <= t_rd[j-1];
      end
      t_valid[0]    <= id_valid & ~stall & ~flush;
      t_regwrite[0] <= id_regwrite;
      t_memread[0]  <= id_memread;
      t_rd[0]       <= id_rd;
      if (stall || flush) begin
        ex_fwd_sel <= '0;
        ex_fwd_mm  <= 1'b0;
      end else begin
        ex_fwd_sel <= sel_next;
        ex_fwd_mm  <= mm_next;
      end
    end
  end

`ifdef FWD_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!ext_hold) begin
      if (flush && !stall)
        stall_count <= '0;
      else if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX/MEM, MEM/WB forwarding unit.
- Keeps its own in-flight destination-tag pipeline, so only the decode-stage fields come in.
- Issues registered per-operand forwarding selects, timed for the start of EX.
- Detects load-use hazards and drives a combinational stall, and handles MEM-to-MEM store-data forwarding.
- Sits beside the ID/EX register and drives the EX operand muxes.

Parameters:
- REG_BITS, 4: register address width; register 0 is hardwired zero and never matches.
- NUM_SRC, 2: number of source operands tracked; source index 1 is the store-data operand.
- FWD_DEPTH, 2: number of tracked post-EX positions p1..pFWD_DEPTH; p1 = EX/MEM, p2 = MEM/WB.
- LOAD_STAGE, 2: first position at which load data can be forwarded; legal range 2..FWD_DEPTH.
- SEL_W (derived): clog2(FWD_DEPTH+1).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- id_valid, input, 1: the ID-stage instruction is valid.
- id_regwrite, input, 1: the ID instruction writes id_rd.
- id_memread, input, 1: the ID instruction is a load.
- id_memwrite, input, 1: the ID instruction is a store; source 1 is its store data.
- id_rd, input, REG_BITS: destination register of the ID instruction.
- id_src, input, NUM_SRC*REG_BITS: source registers; operand i occupies bits [i*REG_BITS +: REG_BITS].
- id_src_used, input, NUM_SRC: per-operand read enable.
- ext_hold, input, 1: global pipeline freeze, e.g. a memory wait.
- flush, input, 1: kill the ID and EX instructions (branch resolved in EX).
- stall, output, 1: combinational; hold PC and IF/ID, and inject a bubble into EX.
- ex_fwd_sel, output, NUM_SRC*SEL_W: registered; 0 selects the register file, k selects the result at pk.
- ex_fwd_mm, output, 1: registered; in MEM, replace the store data with the MEM/WB load data.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low. The interface is decided on this basis.
- Internal state: tag pipeline entries p0..p(FWD_DEPTH-1), each holding {valid, regwrite, memread, rd}. p0 is the instruction now in EX.
- Hazard evaluation, per operand i with id_src_used[i]=1 and src != 0:
  - Compare src against entries pj that are valid, have regwrite=1 and have rd=src.
  - The distance is d = j+1, i.e. the position the producer will hold when the ID instruction reaches EX.
  - The youngest match (smallest d) wins. No match, or src = 0, gives select 0.
- Load-use: if the winning producer has memread=1 and d < LOAD_STAGE, then stall=1. One exception applies (next bullet).
- MEM-to-MEM exception: when all of the following hold, that operand does not stall and next_mm=1; its select is 0:
  - i = 1;
  - id_memwrite=1;
  - the winner is p0, a load;
  - LOAD_STAGE = 2.
- stall output: stall = id_valid & any operand hazard & ~flush.
  - Asserted during ext_hold if a hazard exists; it is ignored by the pipeline while held.
  - Re-evaluated every cycle. With LOAD_STAGE=3, a distance-1 load gives 2 stall cycles, a distance-2 load gives 1.
- Rising edge, ext_hold=0:
  - The tags shift pj -> pj+1 and the oldest entry is dropped.
  - p0 <= ID fields if id_valid & ~stall & ~flush; otherwise a bubble (valid=0).
  - ex_fwd_sel <= computed selects; ex_fwd_mm <= next_mm.
  - On stall or flush, ex_fwd_sel <= 0 and ex_fwd_mm <= 0.
- flush: invalidates the instruction entering p0. It also invalidates the current p0 before the shift, so p1 gets a bubble. Older entries are unaffected.
- ext_hold=1: all state and outputs are frozen. flush is ignored while held.
- Simultaneous flush and stall: flush wins; stall is 0.
- Reset state: all valid bits 0, ex_fwd_sel=0, ex_fwd_mm=0. stall is 0 because no entry is valid.
- Reset mid-operation: all tracked producers are discarded immediately (asynchronous).
- Latency: selects are valid in the cycle after the instruction leaves ID, i.e. during EX.

Optional Feature:
- Macro: FWD_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count [15:0], reset to 0.
  - Increments by 1 on each edge where stall=1 and ext_hold=0. Saturates at 16'hFFFF.
  - Clears synchronously when flush=1 and stall=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (defaults FWD_DEPTH=2, LOAD_STAGE=2):
- ALU r3 <- x, then ALU r5 <- r3 op r3 back-to-back -> stall=0; next cycle ex_fwd_sel={1,1}.
- r3 writer, an independent instruction, then a reader of r3 on operand 0 -> ex_fwd_sel[0]=2. Writers of r3 at both p0 and p1 -> select 1 (youngest wins).
- Load r4, then ADD r6,r4,r2 -> stall=1 for exactly 1 cycle with a bubble in p0; the following cycle ex_fwd_sel[0]=2, ex_fwd_sel[1]=0.
- Load r4, then store with data r4 on operand 1 and base r2 -> stall=0, ex_fwd_mm=1, ex_fwd_sel[1]=0. Same pattern with base r4 on operand 0 -> stall=1.
- Writer of r0, then reader of r0 -> select 0. Operand with id_src_used=0 matching a load -> no stall.
- flush asserted with a dependent reader in ID -> stall=0, ex_fwd_sel=0, p1 bubble. rst_n pulsed low mid-sequence -> outputs 0 asynchronously, no forwarding afterward. Load-use under ext_hold=1 for 3 cycles -> state frozen, then 1 stall cycle.
